// File: rtl/counter_sched_if.sv
// Control/status bundle for counter_sched.
// The master drives the requests and config, the slave (the sequencer) returns
// the count and status.
interface counter_sched_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             stop;
   logic             hold;
   logic             tick;
   logic [WIDTH-1:0] cfg_limit;
   logic             cfg_mode;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             done;
   logic             err;
   logic [1:0]       state;

   modport master (
      output start, stop, hold, tick, cfg_limit, cfg_mode,
      input  count, busy, done, err, state
   );

   modport slave (
      input  start, stop, hold, tick, cfg_limit, cfg_mode,
      output count, busy, done, err, state
   );
endinterface

// File: rtl/counter_sched.sv
// Count-sequencing controller.
// It arms, paces, pauses and terminates an up-count against a limit that is
// latched when start is accepted. It runs in one-shot or auto-reload mode.
// Every output comes straight from a register, so there is no combinational
// path from the inputs to the outputs.
module counter_sched #(
   parameter int WIDTH = 8
) (
   input  logic            clk,
   input  logic            rst,
   counter_sched_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_HOLD = 2'b10,
      S_DONE = 2'b11
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] limit_q;
   logic             mode_q;
   logic             busy_q;
   logic             done_q;
   logic             err_q;

   // A start request is only legal with a non-zero limit.
   logic start_ok;
   assign start_ok = (bus.cfg_limit != '0);

   // The count has reached the latched limit, so a tick here is terminal.
   logic at_limit;
   assign at_limit = (count_q == limit_q);

   // Sequencer FSM.
   // Within a cycle the priority is stop > start > hold > tick. The done and
   // err pulses fall to zero unless they are re-armed in this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         count_q <= '0;
         limit_q <= '0;
         mode_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if (bus.stop) begin
            // In IDLE, stop still wins arbitration but leaves everything as it is.
            if (state_q != S_IDLE) begin
               state_q <= S_IDLE;
               count_q <= '0;
               busy_q  <= 1'b0;
            end
         end else if (bus.start) begin
            if (start_ok) begin
               // Arm, or restart from any state. A tick in this same cycle is dropped.
               limit_q <= bus.cfg_limit;
               mode_q  <= bus.cfg_mode;
               count_q <= '0;
               state_q <= S_RUN;
               busy_q  <= 1'b1;
            end else begin
               // Rejected: only the error pulse changes.
               err_q <= 1'b1;
            end
         end else begin
            unique case (state_q)
               S_RUN: begin
                  if (bus.hold) begin
                     state_q <= S_HOLD;
                  end else if (bus.tick) begin
                     if (at_limit) begin
                        done_q <= 1'b1;
                        if (mode_q) begin
                           count_q <= '0;
                        end else begin
                           state_q <= S_DONE;
                           busy_q  <= 1'b0;
                        end
                     end else begin
                        count_q <= count_q + WIDTH'(1);
                     end
                  end
               end
               S_HOLD: begin
                  // Ticks seen in HOLD are discarded, not queued up.
                  if (!bus.hold) begin
                     state_q <= S_RUN;
                  end
               end
               S_DONE: begin
                  // Park here with count at the limit until start, stop or rst.
               end
               default: begin
                  // IDLE: ticks have no effect.
               end
            endcase
         end
      end
   end

   assign bus.count = count_q;
   assign bus.state = state_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.err   = err_q;

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched.
// A table of cycle vectors is built up front. Each vector holds the inputs for
// one edge and the outputs expected after that edge. The vectors are replayed
// through a scoreboard queue and compared #1 after each rising edge.
module tb_counter_sched;
   localparam int WIDTH = 8;

   typedef struct {
      string            name;
      logic             rst;
      logic             start;
      logic             stop;
      logic             hold;
      logic             tick;
      logic [WIDTH-1:0] lim;
      logic             mode;
      logic [WIDTH-1:0] e_cnt;
      logic [1:0]       e_st;
      logic             e_busy;
      logic             e_done;
      logic             e_err;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;
   vec_t vecs[$];
   vec_t sb[$];

   counter_sched_if #(.WIDTH(WIDTH)) bus ();

   counter_sched #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Append one vector. The positional order of the arguments is:
   // rst start stop hold tick lim mode | cnt st busy done err
   task automatic add(input string nm, input logic r, input logic s, input logic sp,
                      input logic h, input logic t, input int lim, input logic m,
                      input int c, input logic [1:0] st, input logic b,
                      input logic d, input logic e);
      vec_t v;
      v.name  = nm;
      v.rst   = r;
      v.start = s;
      v.stop  = sp;
      v.hold  = h;
      v.tick  = t;
      v.lim   = WIDTH'(lim);
      v.mode  = m;
      v.e_cnt = WIDTH'(c);
      v.e_st  = st;
      v.e_busy = b;
      v.e_done = d;
      v.e_err  = e;
      vecs.push_back(v);
   endtask

   task automatic check(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0; bus.stop = 1'b0; bus.hold = 1'b0; bus.tick = 1'b0;
      bus.cfg_limit = '0; bus.cfg_mode = 1'b0;

      // Reset, then IDLE ignores tick.
      add("rst1", 1,0,0,0,1, 0,0,  0,2'b00,0,0,0);
      add("rst2", 1,0,0,0,1, 0,0,  0,2'b00,0,0,0);
      add("idle_tick", 0,0,0,0,1, 0,0, 0,2'b00,0,0,0);

      // One-shot, limit 3.
      add("os_start", 0,1,0,0,1, 3,0, 0,2'b01,1,0,0);
      add("os_t1", 0,0,0,0,1, 0,0, 1,2'b01,1,0,0);
      add("os_t2", 0,0,0,0,1, 0,0, 2,2'b01,1,0,0);
      add("os_t3", 0,0,0,0,1, 0,0, 3,2'b01,1,0,0);
      add("os_term", 0,0,0,0,1, 0,0, 3,2'b11,0,1,0);
      for (int i = 0; i < 10; i++) add("os_park", 0,0,0,0,1, 0,0, 3,2'b11,0,0,0);

      // Auto-reload, limit 2, with a 4-cycle hold at count 1.
      add("ar_start", 0,1,0,0,0, 2,1, 0,2'b01,1,0,0);
      add("ar_t1", 0,0,0,0,1, 0,0, 1,2'b01,1,0,0);
      add("ar_t2", 0,0,0,0,1, 0,0, 2,2'b01,1,0,0);
      add("ar_wrap1", 0,0,0,0,1, 0,0, 0,2'b01,1,1,0);
      add("ar_t4", 0,0,0,0,1, 0,0, 1,2'b01,1,0,0);
      add("ar_t5", 0,0,0,0,1, 0,0, 2,2'b01,1,0,0);
      add("ar_wrap2", 0,0,0,0,1, 0,0, 0,2'b01,1,1,0);
      add("ar_t7", 0,0,0,0,1, 0,0, 1,2'b01,1,0,0);
      for (int i = 0; i < 4; i++) add("ar_hold", 0,0,0,1,1, 0,0, 1,2'b10,1,0,0);
      add("ar_release", 0,0,0,0,1, 0,0, 1,2'b01,1,0,0);
      add("ar_resume", 0,0,0,0,1, 0,0, 2,2'b01,1,0,0);
      add("ar_wrap3", 0,0,0,0,1, 0,0, 0,2'b01,1,1,0);

      // Restart in RUN: the tick in the restart cycle is dropped, and limit 4 takes effect.
      add("pr_start9", 0,1,0,0,0, 9,0, 0,2'b01,1,0,0);
      for (int i = 1; i <= 5; i++) add("pr_walk", 0,0,0,0,1, 0,0, i,2'b01,1,0,0);
      add("pr_restart", 0,1,0,0,1, 4,0, 0,2'b01,1,0,0);
      for (int i = 1; i <= 4; i++) add("pr_walk4", 0,0,0,0,1, 0,0, i,2'b01,1,0,0);
      add("pr_term4", 0,0,0,0,1, 0,0, 4,2'b11,0,1,0);
      add("pr_start9b", 0,1,0,0,0, 9,0, 0,2'b01,1,0,0);
      add("pr_t1", 0,0,0,0,1, 0,0, 1,2'b01,1,0,0);
      add("pr_stop_start", 0,1,1,0,1, 5,0, 0,2'b00,0,0,0);

      // Rejected start, from IDLE and from RUN.
      add("rej_idle", 0,1,0,0,1, 0,1, 0,2'b00,0,0,1);
      add("rej_idle_post", 0,0,0,0,0, 0,0, 0,2'b00,0,0,0);
      add("rej_start9", 0,1,0,0,0, 9,0, 0,2'b01,1,0,0);
      add("rej_t1", 0,0,0,0,1, 0,0, 1,2'b01,1,0,0);
      add("rej_t2", 0,0,0,0,1, 0,0, 2,2'b01,1,0,0);
      add("rej_run", 0,1,0,0,1, 0,1, 2,2'b01,1,0,1);
      add("rej_run_post", 0,0,0,0,0, 0,0, 2,2'b01,1,0,0);
      // The latched limit 9 and one-shot mode must still be in force.
      for (int i = 3; i <= 9; i++) add("rej_keep", 0,0,0,0,1, 0,0, i,2'b01,1,0,0);
      add("rej_term9", 0,0,0,0,1, 0,0, 9,2'b11,0,1,0);
      add("stop_done", 0,0,1,0,1, 0,0, 0,2'b00,0,0,0);

      // Reset at the terminal edge of a full-range one-shot.
      add("rr_start", 0,1,0,0,0, 255,0, 0,2'b01,1,0,0);
      for (int i = 1; i <= 255; i++) add("rr_walk", 0,0,0,0,1, 0,0, i,2'b01,1,0,0);
      add("rr_reset", 1,0,0,0,1, 0,0, 0,2'b00,0,0,0);
      add("rr_post", 0,0,0,0,1, 0,0, 0,2'b00,0,0,0);

      foreach (vecs[k]) begin
         rst           = vecs[k].rst;
         bus.start     = vecs[k].start;
         bus.stop      = vecs[k].stop;
         bus.hold      = vecs[k].hold;
         bus.tick      = vecs[k].tick;
         bus.cfg_limit = vecs[k].lim;
         bus.cfg_mode  = vecs[k].mode;
         sb.push_back(vecs[k]);
         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            check("sb_underflow", 0, 1);
         end else begin
            vec_t e;
            e = sb.pop_front();
            check({e.name, ".count"}, int'(bus.count), int'(e.e_cnt));
            check({e.name, ".state"}, int'(bus.state), int'(e.e_st));
            check({e.name, ".busy"},  int'(bus.busy),  int'(e.e_busy));
            check({e.name, ".done"},  int'(bus.done),  int'(e.e_done));
            check({e.name, ".err"},   int'(bus.err),   int'(e.e_err));
         end
      end
      check("sb_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
